// File: rtl/softmax_sum_acc_pkg.sv
// Shared softmax definitions: float format, row-accumulator FSM states and
// the float zero encoding.
package softmax_sum_acc_pkg;

  localparam int SOFTMAX_SIG_WIDTH = 8;
  localparam int SOFTMAX_EXP_WIDTH = 7;
  localparam int SOFTMAX_DATA_BIT  = SOFTMAX_SIG_WIDTH + SOFTMAX_EXP_WIDTH + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  localparam logic [SOFTMAX_DATA_BIT-1:0] FP_ZERO = {SOFTMAX_DATA_BIT{1'b0}};

endpackage

// File: rtl/DW_fp_add.sv
// Port-compatible implementation of the DesignWare DW_fp_add adder (status port
// not provided). Denormals are flushed to zero and NaNs are treated as infinities.
module DW_fp_add #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z
);

  localparam int MW = sig_width + 4;
  localparam logic [exp_width-1:0] EXP_ONES  = {exp_width{1'b1}};
  localparam logic [exp_width-1:0] EXP_ZEROS = {exp_width{1'b0}};

  logic                 sa, sb, s_big, s_sml;
  logic [exp_width-1:0] ea, eb, e_big, e_sml, dexp;
  logic [sig_width-1:0] fa, fb, f_big, f_sml, f_res;
  logic                 a_inf, b_inf, a_zero, b_zero, swap, found, round_up;
  logic [MW-1:0]        m_big, m_sml, m_shift, mask, m_norm;
  logic [MW:0]          m_sum;
  logic [sig_width+1:0] m_rnd;
  int                   lz, e_res;

  // Align, add/subtract, normalise, round to nearest even, then select special cases.
  always_comb begin
    sa = a[sig_width+exp_width];
    ea = a[sig_width+exp_width-1:sig_width];
    fa = a[sig_width-1:0];
    sb = b[sig_width+exp_width];
    eb = b[sig_width+exp_width-1:sig_width];
    fb = b[sig_width-1:0];
    a_inf  = (ea == EXP_ONES);
    b_inf  = (eb == EXP_ONES);
    a_zero = (ea == EXP_ZEROS);
    b_zero = (eb == EXP_ZEROS);

    swap  = ({ea, fa} < {eb, fb});
    s_big = swap ? sb : sa;
    s_sml = swap ? sa : sb;
    e_big = swap ? eb : ea;
    e_sml = swap ? ea : eb;
    f_big = swap ? fb : fa;
    f_sml = swap ? fa : fb;
    dexp  = e_big - e_sml;

    m_big      = {1'b1, f_big, 3'b000};
    m_sml      = {1'b1, f_sml, 3'b000};
    mask       = ~({MW{1'b1}} << dexp);
    m_shift    = m_sml >> dexp;
    m_shift[0] = m_shift[0] | (|(m_sml & mask));

    if (s_big == s_sml) begin
      m_sum = {1'b0, m_big} + {1'b0, m_shift};
    end else begin
      m_sum = {1'b0, m_big} - {1'b0, m_shift};
    end

    lz    = 0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      lz    = lz + ((found || m_sum[i]) ? 0 : 1);
      found = found | m_sum[i];
    end

    if (m_sum[MW]) begin
      m_norm    = m_sum[MW:1];
      m_norm[0] = m_sum[1] | m_sum[0];
      e_res     = int'(e_big) + 1;
    end else begin
      m_norm = m_sum[MW-1:0] << lz;
      e_res  = int'(e_big) - lz;
    end

    // rnd 1 truncates; every other mode rounds to nearest even.
    round_up = (rnd != 3'd1) && m_norm[2] && (m_norm[3] || m_norm[1] || m_norm[0]);
    m_rnd    = {1'b0, m_norm[MW-1:3]} + {{(sig_width+1){1'b0}}, round_up};
    if (m_rnd[sig_width+1]) begin
      f_res = m_rnd[sig_width:1];
      e_res = e_res + 1;
    end else begin
      f_res = m_rnd[sig_width-1:0];
    end

    if (a_inf || b_inf) begin
      if (a_inf && b_inf && (sa != sb) && (ieee_compliance != 0)) begin
        z = {1'b0, EXP_ONES, {{(sig_width-1){1'b0}}, 1'b1}};
      end else begin
        z = {(a_inf ? sa : sb), EXP_ONES, {sig_width{1'b0}}};
      end
    end else if (a_zero && b_zero) begin
      z = {(sa & sb), EXP_ZEROS, {sig_width{1'b0}}};
    end else if (a_zero) begin
      z = b;
    end else if (b_zero) begin
      z = a;
    end else if (m_sum == {(MW+1){1'b0}}) begin
      z = {1'b0, EXP_ZEROS, {sig_width{1'b0}}};
    end else if (e_res >= int'(EXP_ONES)) begin
      z = {s_big, EXP_ONES, {sig_width{1'b0}}};
    end else if (e_res <= 0) begin
      z = {s_big, EXP_ZEROS, {sig_width{1'b0}}};
    end else begin
      z = {s_big, e_res[exp_width-1:0], f_res};
    end
  end

endmodule

// File: rtl/softmax_sum_acc_recip.sv
// softmax_recip_stage: registered reciprocal of the completed row sum.
// Only present when SOFTMAX_RECIP_EN is defined.
`ifdef SOFTMAX_RECIP_EN
module softmax_recip_stage #(
  parameter int sig_width = 8,
  parameter int exp_width = 7,
  parameter int DATA_BIT  = sig_width + exp_width + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DATA_BIT-1:0] sum_in,
  input  logic                sum_valid,
  output logic [DATA_BIT-1:0] recip_out,
  output logic                recip_valid
);

  logic [DATA_BIT-1:0] recip_s;
  logic [DATA_BIT-1:0] recip_q, recip_d;
  logic                recip_valid_q, recip_valid_d;

  DW_fp_recip #(
    .sig_width      (sig_width),
    .exp_width      (exp_width),
    .ieee_compliance(0),
    .faithful_round (0)
  ) u_recip (
    .a     (sum_in),
    .rnd   (3'b000),
    .z     (recip_s),
    .status()
  );

  // sum_in is stable for the whole sum_valid cycle, so capture on that pulse.
  always_comb begin
    recip_d       = recip_q;
    recip_valid_d = sum_valid;
    if (sum_valid) begin
      recip_d = recip_s;
    end else begin
      recip_d = recip_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      recip_q       <= {DATA_BIT{1'b0}};
      recip_valid_q <= 1'b0;
    end else begin
      recip_q       <= recip_d;
      recip_valid_q <= recip_valid_d;
    end
  end

  assign recip_out   = recip_q;
  assign recip_valid = recip_valid_q;

endmodule
`endif

// File: rtl/softmax_sum_acc.sv
// Softmax denominator row accumulator: chains per-beat partial sums through one
// fp adder. Define SOFTMAX_RECIP_EN to add the registered 1/sum output.
module softmax_sum_acc
  import softmax_sum_acc_pkg::*;
#(
  parameter int sig_width = SOFTMAX_SIG_WIDTH,
  parameter int exp_width = SOFTMAX_EXP_WIDTH,
  parameter int DATA_BIT  = sig_width + exp_width + 1,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DATA_BIT-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic [DATA_BIT-1:0] sum_out,
  output logic                sum_valid,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                cnt_ovf,
  output logic [DATA_BIT-1:0] recip_out,
  output logic                recip_valid
);

  localparam logic [DATA_BIT-1:0] ZERO_W  = DATA_BIT'(FP_ZERO);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

  acc_state_e          state_q, state_d;
  logic [DATA_BIT-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [DATA_BIT-1:0] sum_out_q, sum_out_d;
  logic                sum_valid_q, sum_valid_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                cnt_ovf_q, cnt_ovf_d;

  logic [DATA_BIT-1:0] add_b, nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                ovf_inc;

  always_comb begin
    add_b = in_valid ? in_data : ZERO_W;
  end

  DW_fp_add #(
    .sig_width      (sig_width),
    .exp_width      (exp_width),
    .ieee_compliance(0)
  ) u_add (
    .a  (acc_q),
    .b  (add_b),
    .rnd(3'b000),
    .z  (nxt)
  );

  // Saturating beat count; a beat that finds the counter full marks the row overflowed.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc = cnt_q;
      ovf_inc = 1'b1;
    end else begin
      cnt_inc = cnt_q + CNT_ONE;
      ovf_inc = ovf_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_out_d   = sum_out_q;
    sum_valid_d = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    cnt_ovf_d   = cnt_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_last) begin
          sum_out_d   = in_data;
          beat_cnt_d  = CNT_ONE;
          cnt_ovf_d   = 1'b0;
          sum_valid_d = 1'b1;
          acc_d       = ZERO_W;
          cnt_d       = {CNT_W{1'b0}};
          ovf_d       = 1'b0;
        end else if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (in_last) begin
          sum_out_d   = nxt;
          beat_cnt_d  = in_valid ? cnt_inc : cnt_q;
          cnt_ovf_d   = in_valid ? ovf_inc : ovf_q;
          sum_valid_d = 1'b1;
          acc_d       = ZERO_W;
          cnt_d       = {CNT_W{1'b0}};
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end else if (in_valid) begin
          acc_d = nxt;
          cnt_d = cnt_inc;
          ovf_d = ovf_inc;
        end else begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = ZERO_W;
        cnt_d   = {CNT_W{1'b0}};
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= ZERO_W;
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      sum_out_q   <= ZERO_W;
      sum_valid_q <= 1'b0;
      beat_cnt_q  <= {CNT_W{1'b0}};
      cnt_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      cnt_ovf_q   <= cnt_ovf_d;
    end
  end

  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign beat_cnt  = beat_cnt_q;
  assign cnt_ovf   = cnt_ovf_q;

`ifdef SOFTMAX_RECIP_EN
  softmax_recip_stage #(
    .sig_width(sig_width),
    .exp_width(exp_width),
    .DATA_BIT (DATA_BIT)
  ) u_recip (
    .clk        (clk),
    .rstn       (rstn),
    .sum_in     (sum_out_q),
    .sum_valid  (sum_valid_q),
    .recip_out  (recip_out),
    .recip_valid(recip_valid)
  );
`else
  assign recip_out   = {DATA_BIT{1'b0}};
  assign recip_valid = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_sum_acc.sv
// Scoreboard bench for softmax_sum_acc (CNT_W=2 so saturation is reachable).
module tb_softmax_sum_acc;

  localparam int DW = 16;
  localparam int CW = 2;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic [DW-1:0] sum_out;
  logic          sum_valid;
  logic [CW-1:0] beat_cnt;
  logic          cnt_ovf;
  logic [DW-1:0] recip_out;
  logic          recip_valid;

  typedef struct {
    logic [DW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  softmax_sum_acc #(
    .sig_width(8),
    .exp_width(7),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .beat_cnt   (beat_cnt),
    .cnt_ovf    (cnt_ovf),
    .recip_out  (recip_out),
    .recip_valid(recip_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, expv);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_last  = l;
    in_data  = d;
  endtask

  // Called right after the closing beat is driven: the pulse is due next cycle.
  task automatic expect_row(input logic [DW-1:0] s, input logic [CW-1:0] c, input logic o);
    exp_q.push_back('{sum: s, cnt: c, ovf: o, due: cyc + 1});
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sum_out"}, 32'(sum_out), 32'h0);
    chk({tag, "_sum_valid"}, 32'(sum_valid), 32'h0);
    chk({tag, "_beat_cnt"}, 32'(beat_cnt), 32'h0);
    chk({tag, "_cnt_ovf"}, 32'(cnt_ovf), 32'h0);
    chk({tag, "_recip_out"}, 32'(recip_out), 32'h0);
    chk({tag, "_recip_valid"}, 32'(recip_valid), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rstn && sum_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: actual sum_out=%h beat_cnt=%0d required no pulse",
                 sum_out, beat_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_cycle", cyc, mon_e.due);
        chk("sum_out", 32'(sum_out), 32'(mon_e.sum));
        chk("beat_cnt", 32'(beat_cnt), 32'(mon_e.cnt));
        chk("cnt_ovf", 32'(cnt_ovf), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;
    #3;
    chk_reset_values("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // 1.0 + 2.0 + 3.0 = 6.0
    drive(1'b1, 1'b0, 16'h3F00);
    drive(1'b1, 1'b0, 16'h4000);
    drive(1'b1, 1'b1, 16'h4080); expect_row(16'h4180, 2'd3, 1'b0);
    // single-beat row 4.0, back-to-back with the previous close
    drive(1'b1, 1'b1, 16'h4100); expect_row(16'h4100, 2'd1, 1'b0);
    // row A = 1.0 + 1.0, row B = 2.0 on the next cycle
    drive(1'b1, 1'b0, 16'h3F00);
    drive(1'b1, 1'b1, 16'h3F00); expect_row(16'h4000, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 16'h4000); expect_row(16'h4000, 2'd1, 1'b0);
    drive(1'b0, 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000);

    // gapped 1.5, idle x3, 0.5, then last without valid
    drive(1'b1, 1'b0, 16'h3F80);
    repeat (3) drive(1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h3E00);
    drive(1'b0, 1'b1, 16'h5555); expect_row(16'h4000, 2'd2, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0000);
    chk("hold_sum_out", 32'(sum_out), 32'h4000);
    chk("hold_beat_cnt", 32'(beat_cnt), 32'd2);
    chk("hold_sum_valid", 32'(sum_valid), 32'h0);

    // last without valid while idle is ignored
    drive(1'b0, 1'b1, 16'h1234);
    drive(1'b0, 1'b0, 16'h0000);

    // five beats of 1.0 saturate a 2-bit counter; next row reports clean
    repeat (4) drive(1'b1, 1'b0, 16'h3F00);
    drive(1'b1, 1'b1, 16'h3F00); expect_row(16'h4140, 2'd3, 1'b1);
    drive(1'b1, 1'b1, 16'h3F00); expect_row(16'h3F00, 2'd1, 1'b0);

    // 3.0 + (-1.0) = 2.0
    drive(1'b1, 1'b0, 16'h4080);
    drive(1'b1, 1'b1, 16'hBF00); expect_row(16'h4000, 2'd2, 1'b0);

    // 1.0 + 2^-8 exact, then + 2^-9 is a tie onto an odd lsb: rounds up
    drive(1'b1, 1'b0, 16'h3F00);
    drive(1'b1, 1'b0, 16'h3700);
    drive(1'b1, 1'b1, 16'h3600); expect_row(16'h3F02, 2'd3, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 16'h0000);

    // reset mid-row discards the partial sum
    drive(1'b1, 1'b0, 16'h3F00);
    drive(1'b1, 1'b0, 16'h3F00);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rstn     = 1'b0;
    #2;
    chk_reset_values("midrow");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    drive(1'b1, 1'b1, 16'h41C0); expect_row(16'h41C0, 2'd1, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 16'h0000);

    chk("rows_outstanding", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
